// File: rtl/grid_write_scheduler.sv
// Write sequencer for the 16x16x2-bit VGA grid memory: full-grid clear sweep plus a FIFO of
// single-cell updates drained in arrival order. Define GRID_COALESCE_EN to merge same-cell updates into the FIFO tail.
module grid_write_scheduler #(
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [1:0] CLEAR_VALUE = 2'b00
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       CLEAR_REQ,
    input  logic       UPD_VALID,
    input  logic [3:0] UPD_X,
    input  logic [3:0] UPD_Y,
    input  logic [1:0] UPD_VALUE,
    output logic       MEM_WE,
    output logic [7:0] MEM_ADDR,
    output logic [1:0] MEM_DATA,
    output logic       BUSY,
    output logic [4:0] FIFO_COUNT,
    output logic       OVERFLOW
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [7:0]    sweep_cnt_r;
    logic [9:0]    fifo_mem_r [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] wr_ptr_r;
    logic [9:0]    head_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          clear_start_s;
    logic          pop_s;
    logic          push_s;
    logic          coalesce_s;
    logic          drop_s;
    logic          we_s;
    logic [7:0]    addr_s;
    logic [1:0]    data_s;
    logic          busy_s;
`ifdef GRID_COALESCE_EN
    logic [PW-1:0] tail_ptr_s;
    logic [9:0]    tail_s;
`endif

    // FIFO push/pop/drop decisions for this cycle
    always_comb begin
        fifo_empty_s  = (FIFO_COUNT == 5'd0);
        fifo_full_s   = (FIFO_COUNT == 5'(FIFO_DEPTH));
        clear_start_s = (state_r == ST_IDLE) && CLEAR_REQ;
        pop_s         = (state_r == ST_IDLE) && !CLEAR_REQ && !fifo_empty_s;
        head_s        = fifo_mem_r[rd_ptr_r];
`ifdef GRID_COALESCE_EN
        tail_ptr_s    = wr_ptr_r - PW'(1);
        tail_s        = fifo_mem_r[tail_ptr_s];
        // A tail that leaves this cycle cannot absorb the update.
        coalesce_s    = UPD_VALID && !fifo_empty_s && (tail_s[9:2] == {UPD_Y, UPD_X})
                        && !(pop_s && (FIFO_COUNT == 5'd1));
`else
        coalesce_s    = 1'b0;
`endif
        push_s        = UPD_VALID && !coalesce_s && (!fifo_full_s || pop_s);
        drop_s        = UPD_VALID && !coalesce_s && fifo_full_s && !pop_s;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (sweep_cnt_r == 8'hFF) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (CLEAR_REQ) begin
                    state_s = ST_CLEAR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            default: state_s = ST_CLEAR;
        endcase
    end

    // Next values of the registered memory-port outputs
    always_comb begin
        we_s   = 1'b0;
        addr_s = MEM_ADDR;
        data_s = MEM_DATA;
        busy_s = (state_r == ST_CLEAR) || clear_start_s;
        case (state_r)
            ST_CLEAR: begin
                we_s   = 1'b1;
                addr_s = sweep_cnt_r;
                data_s = CLEAR_VALUE;
            end
            ST_IDLE: begin
                if (pop_s) begin
                    we_s   = 1'b1;
                    addr_s = head_s[9:2];
                    data_s = head_s[1:0];
                end else begin
                    we_s   = 1'b0;
                end
            end
            default: begin
                we_s = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_s;
        end
    end

    // Sweep address counter; its 255->0 wrap coincides with leaving CLEAR
    always_ff @(posedge CLOCK_50) begin
        if (RESET || clear_start_s) begin
            sweep_cnt_r <= 8'd0;
        end else if (state_r == ST_CLEAR) begin
            sweep_cnt_r <= sweep_cnt_r + 8'd1;
        end else begin
            sweep_cnt_r <= sweep_cnt_r;
        end
    end

    // Registered memory port and status outputs
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            MEM_WE   <= 1'b0;
            MEM_ADDR <= 8'd0;
            MEM_DATA <= 2'b00;
            BUSY     <= 1'b1;
        end else begin
            MEM_WE   <= we_s;
            MEM_ADDR <= addr_s;
            MEM_DATA <= data_s;
            BUSY     <= busy_s;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            FIFO_COUNT <= 5'd0;
            OVERFLOW   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   FIFO_COUNT <= FIFO_COUNT + 5'd1;
                2'b01:   FIFO_COUNT <= FIFO_COUNT - 5'd1;
                default: FIFO_COUNT <= FIFO_COUNT;
            endcase
            if (drop_s) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

    // FIFO storage
    always_ff @(posedge CLOCK_50) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {UPD_Y, UPD_X, UPD_VALUE};
`ifdef GRID_COALESCE_EN
        end else if (coalesce_s) begin
            fifo_mem_r[tail_ptr_s][1:0] <= UPD_VALUE;
`endif
        end
    end

endmodule

// File: doc/grid_write_scheduler.md
# grid_write_scheduler

Sequences all writes into the 16x16, 2-bit-per-cell grid memory that the VGA side renders. It arbitrates between a full-grid clear sweep and single-cell updates strobed in from the GPIO receive front end. Updates that arrive during a sweep are buffered in a small FIFO and drained afterwards. The memory sees at most one write per cycle.

## Interface
Parameters:
- FIFO_DEPTH, 4: update FIFO entries; power of two, 2..16.
- CLEAR_VALUE, 2'b00: value written to every cell by a clear sweep.

Ports:
- CLOCK_50  in  1  sole clock; all logic on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CLEAR_REQ  in  1  one-cycle pulse; requests a full-grid clear.
- UPD_VALID  in  1  one-cycle pulse; UPD_X/UPD_Y/UPD_VALUE valid this cycle.
- UPD_X  in  4  cell column.
- UPD_Y  in  4  cell row.
- UPD_VALUE  in  2  cell value.
- MEM_WE  out  1  registered write enable to grid memory.
- MEM_ADDR  out  8  registered address, {Y, X}.
- MEM_DATA  out  2  registered write data.
- BUSY  out  1  high while a clear sweep is in progress.
- FIFO_COUNT  out  5  current FIFO occupancy, 0..FIFO_DEPTH.
- OVERFLOW  out  1  sticky; set when an update is dropped; cleared only by RESET.

## Operation
- States: CLEAR, IDLE.
- RESET high: state <= CLEAR, sweep counter <= 0, FIFO emptied. MEM_WE, MEM_ADDR, MEM_DATA, FIFO_COUNT and OVERFLOW all 0. BUSY 1.
- CLEAR state:
  - Each cycle: MEM_WE=1, MEM_ADDR=counter, MEM_DATA=CLEAR_VALUE, then counter +1.
  - After writing address 255, go to IDLE.
  - The counter is 8 bits; the wrap from 255 to 0 is the exit condition.
  - CLEAR_REQ during CLEAR is ignored; the sweep does not restart.
- IDLE state:
  - CLEAR_REQ has priority: go to CLEAR with counter 0. No FIFO pop that cycle.
  - Otherwise, if the FIFO is non-empty, pop the head and issue MEM_WE=1 with its {Y,X} and value.
  - Otherwise MEM_WE=0. MEM_ADDR and MEM_DATA hold their last values.
- Push:
  - Every UPD_VALID pulse pushes {UPD_Y, UPD_X, UPD_VALUE} in any state.
  - If the FIFO is full and no pop occurs the same cycle, the update is dropped and OVERFLOW is set.
  - Simultaneous push and pop when full: both occur and FIFO_COUNT is unchanged.
  - Simultaneous push and pop when empty: the entry is stored and popped on a later cycle. There is no bypass.
- FIFO ordering is strict; updates reach memory in arrival order.

## Timing
- Clear sweep: exactly 256 consecutive MEM_WE cycles, addresses 0..255 ascending.
  - The first clear write is registered on the first rising edge with RESET low.
  - BUSY is high through the cycle presenting address 255 and low from the next cycle.
- Update latency when idle and FIFO empty:
  - UPD_VALID sampled at edge N.
  - Entry popped at edge N+1.
  - MEM_WE high in the cycle after edge N+1, i.e. two cycles after the pulse.
- Drain rate: one entry per cycle, back-to-back, with no idle bubbles.
- FIFO_COUNT and OVERFLOW are registered and update on the edge where the push or pop takes effect.
- RESET mid-sweep or mid-drain aborts immediately. FIFO contents are lost and the sweep restarts from address 0.

## Configuration
- GRID_COALESCE_EN defined:
  - A pushed update whose {Y,X} equals the FIFO tail entry's address overwrites the tail's value instead of allocating a new entry.
  - The tail is the most recent entry not yet popped.
  - FIFO_COUNT does not change and OVERFLOW is not set, even when the FIFO is full.
  - If the tail is being popped that same cycle, no coalescing occurs; a normal push happens.
- GRID_COALESCE_EN undefined: every update allocates an entry, as described in Operation.

## Test plan
- Reset release: RESET high 3 cycles, then low -> 256 writes, addr 0..255, data 2'b00, BUSY falls after addr 255, then MEM_WE=0.
- Idle update: after sweep, UPD_VALID with X=3, Y=5, VALUE=2 -> MEM_WE=1, MEM_ADDR=8'h53, MEM_DATA=2 exactly two cycles later; FIFO_COUNT returns to 0.
- Buffer during clear: CLEAR_REQ, then 3 updates at sweep cycles 10, 11, 12 -> FIFO_COUNT=3; after addr 255, three back-to-back writes in arrival order.
- Overflow: FIFO_DEPTH=4; 6 distinct updates during a sweep -> first 4 written after the sweep, last 2 never written, OVERFLOW=1 until RESET.
- Priority: CLEAR_REQ in the same cycle the FIFO holds 2 entries -> next write is addr 0 with CLEAR_VALUE; both entries drain after addr 255.
- Coalesce (GRID_COALESCE_EN): two updates to X=1, Y=1 with values 1 then 3 during a sweep -> FIFO_COUNT=1; a single write of value 3 to 8'h11 after the sweep.
